// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus generator and checker for an N-input, 1-output combinational DUT.
// Sweeps every input vector, compares the sampled output with a golden truth table and reports the results.
module truth_table_sweeper #(
    parameter int                   N_IN        = 4,
    parameter int                   HOLD_CYCLES = 20,
    parameter logic [(2**N_IN)-1:0] EXPECTED    = '0,
    parameter int                   CNT_W       = N_IN + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             loop_en,
    input  logic             abort,
    input  logic             dut_out,
    output logic [N_IN-1:0]  stim,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [N_IN-1:0]  first_fail_vec,
    output logic             first_fail_valid,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int               HW        = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CYCLES - 2);
    localparam logic [N_IN-1:0]  STIM_LAST = '1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t             state, state_d;
    logic [HW-1:0]      hold_cnt, hold_d;
    logic [N_IN-1:0]    stim_d, ffv_d;
    logic [CNT_W-1:0]   err_d;
    logic               ffvalid_d, pass_d, done_d, busy_d;
    logic               restart, mismatch;

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            stim             <= '0;
            hold_cnt         <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            state            <= state_d;
            stim             <= stim_d;
            hold_cnt         <= hold_d;
            busy             <= busy_d;
            done             <= done_d;
            pass             <= pass_d;
            err_count        <= err_d;
            first_fail_vec   <= ffv_d;
            first_fail_valid <= ffvalid_d;
        end
    end

    always_comb begin
        state_d   = state;
        stim_d    = stim;
        hold_d    = hold_cnt;
        err_d     = err_count;
        ffv_d     = first_fail_vec;
        ffvalid_d = first_fail_valid;
        pass_d    = pass;
        done_d    = 1'b0;
        restart   = 1'b0;
        mismatch  = (dut_out != EXPECTED[stim]);

        if (abort && (state != IDLE)) begin
            // Results of the partial sweep stay visible; only the stimulus is parked.
            state_d = IDLE;
            stim_d  = '0;
            hold_d  = '0;
            pass_d  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        restart = 1'b1;
                        pass_d  = 1'b0;
                    end
                end
                DRIVE: begin
                    hold_d = hold_cnt + 1'b1;
                    if (hold_cnt == HOLD_LAST) state_d = SAMPLE;
                end
                SAMPLE: begin
                    if (mismatch) begin
                        if (err_count != CNT_MAX) err_d = err_count + 1'b1;
                        if (!first_fail_valid) begin
                            ffv_d     = stim;
                            ffvalid_d = 1'b1;
                        end
                    end
                    if (stim == STIM_LAST) begin
                        state_d = DONE;
                    end else begin
                        stim_d  = stim + 1'b1;
                        hold_d  = '0;
                        state_d = DRIVE;
                    end
                end
                DONE: begin
                    // err_count already includes the final compare made in SAMPLE.
                    done_d = 1'b1;
                    pass_d = (err_count == '0);
                    if (loop_en) restart = 1'b1;
                    else         state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase

            if (restart) begin
                state_d   = DRIVE;
                stim_d    = '0;
                hold_d    = '0;
                err_d     = '0;
                ffvalid_d = 1'b0;
            end
        end

        busy_d = (state_d == DRIVE) || (state_d == SAMPLE);
    end

endmodule
